// File: rtl/regfile_wb_writer.sv
// Register-file write-back serializer: ALU/load/multiply/call results are queued and issued one write per cycle.
// Optional build macro ZERO_REG_GUARD_EN: accepted ALU/load results targeting r0 are acknowledged and dropped.
module regfile_wb_writer #(
    parameter int         DEPTH  = 4,
    parameter int         CW     = 2,
    parameter logic [4:0] HI_REG = 5'd19,
    parameter logic [4:0] LO_REG = 5'd20,
    parameter logic [4:0] RA_REG = 5'd5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_dest,
    input  logic [31:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_dest,
    input  logic [31:0]   mem_data,
    input  logic          mult_valid,
    output logic          mult_ready,
    input  logic [31:0]   mult_hi,
    input  logic [31:0]   mult_lo,
    input  logic          call_valid,
    output logic          call_ready,
    input  logic [31:0]   call_ra,
    output logic          wr_en,
    input  logic          wr_ready,
    output logic [4:0]    wr_addr,
    output logic [31:0]   wr_data,
    output logic [CW:0]   fifo_count
);

    typedef enum logic {
        S_RUN,
        S_MULT_LO
    } state_t;

    localparam logic [CW+1:0] FREE_DEPTH = DEPTH[CW+1:0];
    localparam logic [CW+1:0] FREE_ONE   = 1;
    localparam logic [CW+1:0] FREE_TWO   = 2;
    localparam logic [CW-1:0] PTR_ONE    = 1;
    localparam logic [CW:0]   CNT_ONE    = 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW:0]     count_q, count_d;
    logic [31:0]     lo_q, lo_d;

    logic [4:0]      fifo_addr_q [DEPTH];
    logic [31:0]     fifo_data_q [DEPTH];

    logic            pop;
    logic            push;
    logic [4:0]      push_addr;
    logic [31:0]     push_data;
    logic [CW+1:0]   free_slots;
    logic            run;
    logic            fit1;
    logic            fit2;

    // Head is exposed directly; gating with wr_en keeps the port at zero while empty.
    assign wr_en      = (count_q != '0);
    assign pop        = wr_en && wr_ready;
    assign wr_addr    = wr_en ? fifo_addr_q[rd_ptr_q] : 5'd0;
    assign wr_data    = wr_en ? fifo_data_q[rd_ptr_q] : 32'd0;
    assign fifo_count = count_q;

    assign free_slots = FREE_DEPTH - {1'b0, count_q} + (pop ? FREE_ONE : '0);
    assign fit1       = (free_slots >= FREE_ONE);
    assign fit2       = (free_slots >= FREE_TWO);
    assign run        = (state_q == S_RUN) && !rst;

    always_comb begin
        call_ready = run && call_valid && fit1;
        mult_ready = run && mult_valid && !call_valid && fit2;
        mem_ready  = run && mem_valid && !call_valid && !mult_valid && fit1;
        alu_ready  = run && alu_valid && !call_valid && !mult_valid && !mem_valid && fit1;
    end

    // Selects what enters the FIFO this cycle; the low product word always follows its high word.
    always_comb begin
        push      = 1'b0;
        push_addr = alu_dest;
        push_data = alu_data;
        state_d   = state_q;
        lo_d      = lo_q;
        if (state_q == S_MULT_LO) begin
            push      = 1'b1;
            push_addr = LO_REG;
            push_data = lo_q;
            state_d   = S_RUN;
        end else if (call_ready) begin
            push      = 1'b1;
            push_addr = RA_REG;
            push_data = call_ra;
        end else if (mult_ready) begin
            push      = 1'b1;
            push_addr = HI_REG;
            push_data = mult_hi;
            lo_d      = mult_lo;
            state_d   = S_MULT_LO;
        end else if (mem_ready) begin
`ifdef ZERO_REG_GUARD_EN
            push      = (mem_dest != 5'd0);
`else
            push      = 1'b1;
`endif
            push_addr = mem_dest;
            push_data = mem_data;
        end else if (alu_ready) begin
`ifdef ZERO_REG_GUARD_EN
            push      = (alu_dest != 5'd0);
`else
            push      = 1'b1;
`endif
            push_addr = alu_dest;
            push_data = alu_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lo_q     <= lo_d;
        end
    end

    // Entry storage needs no reset: nothing reads an entry before it has been written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst && push && (wr_ptr_q == CW'(gi))) begin
                fifo_addr_q[gi] <= push_addr;
                fifo_data_q[gi] <= push_data;
            end
        end
    end

endmodule
